song_recorder: RTL and testbench
================================

SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set the maximum number of stored notes.
REQ-002 Parameter DUR_W, default 26, SHALL set the duration counter width in clk cycles.
REQ-003 Parameter GAP, default 1, SHALL set the key_on-low cycles inserted after each played note.
REQ-004 clk  in  1  system clock; all inputs are synchronous to clk and already debounced.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 key_on_in  in  1  live keyboard "key held" flag.
REQ-007 key_in  in  4  live keyboard note index (0-15).
REQ-008 rec_start  in  1  one-cycle pulse: clear buffer, arm recording.
REQ-009 play_start  in  1  one-cycle pulse: replay buffer.
REQ-010 stop  in  1  one-cycle pulse: end recording or abort playback.
REQ-011 key_on  out  1  playback note-active flag.
REQ-012 key  out  4  playback note index.
REQ-013 recording  out  1  high in REC_ARMED or REC_HOLD.
REQ-014 playing  out  1  high in PLAY_NOTE or PLAY_GAP.
REQ-015 full  out  1  note_count == DEPTH.
REQ-016 note_count  out  $clog2(DEPTH)+1  number of stored notes.
REQ-017 play_done  out  1  one-cycle pulse when playback completes normally.

Function
REQ-018 The FSM SHALL have states IDLE, REC_ARMED, REC_HOLD, PLAY_NOTE and PLAY_GAP.
REQ-019 In IDLE, rec_start SHALL clear note_count and write pointer and enter REC_ARMED on the next cycle; rec_start SHALL take priority over a simultaneous play_start.
REQ-020 In IDLE, play_start SHALL be ignored when note_count == 0; otherwise it SHALL set the read pointer to 0 and enter PLAY_NOTE.
REQ-021 In REC_ARMED, key_on_in == 1 SHALL latch key_in, set the duration counter to 1 and enter REC_HOLD.
REQ-022 In REC_HOLD, each cycle with key_on_in == 1 and key_in unchanged SHALL increment the duration counter, saturating at 2^DUR_W-1.
REQ-023 In REC_HOLD, key_on_in == 0 SHALL commit {latched key, counter} to buffer[write pointer], increment note_count and return to REC_ARMED.
REQ-024 In REC_HOLD, a key_in change while key_on_in == 1 SHALL commit the current note and in the same cycle start a new note with the new key and counter = 1.
REQ-025 When a commit makes note_count == DEPTH, the FSM SHALL enter IDLE, and further input SHALL be ignored until the next rec_start.
REQ-026 stop in REC_HOLD SHALL commit the held note and then enter IDLE; stop in REC_ARMED SHALL enter IDLE without a write.
REQ-027 In PLAY_NOTE, key SHALL equal the stored key and key_on SHALL be 1 for exactly the stored duration cycles, after which the FSM SHALL enter PLAY_GAP.
REQ-028 In PLAY_GAP, key_on SHALL be 0 for GAP cycles; the FSM SHALL then advance to the next note, or enter IDLE and pulse play_done after the last note.
REQ-029 stop during playback SHALL drive key_on to 0 on the next cycle and enter IDLE without a play_done pulse.
REQ-030 rec_start and play_start SHALL be ignored outside IDLE; stop SHALL be ignored in IDLE.
REQ-031 key SHALL hold its last value when key_on == 0.

Reset
REQ-032 rst SHALL force IDLE, key_on = 0, key = 0, play_done = 0, note_count = 0 and all pointers and counters to 0, including mid-record and mid-playback.
REQ-033 Buffer contents need not be reset; they SHALL be unreadable while note_count == 0.

Structure
REQ-034 KEY_W (4) and the FSM state enumeration SHALL reside in the shared package piano_pkg.
REQ-035 Storage SHALL be a sub-module note_buffer: DEPTH x (KEY_W+DUR_W), one synchronous write port and one read port.

Verification (DUR_W = 8, GAP = 1, DEPTH = 4)
REQ-036 rec_start; key 2 held 5 cycles; release; stop; play_start -> key = 2, key_on high for exactly 5 cycles, then low for 1 cycle, then play_done pulse; note_count = 1.
REQ-037 During recording, key 3 is held for 300 cycles -> stored duration = 255, and playback holds key_on for 255 cycles.
REQ-038 During recording, key 1 is held 4 cycles and then key_in changes to 4 without release for 6 cycles -> two notes (1,4) and (4,6) are stored, note_count = 2.
REQ-039 Record five presses -> full = 1 and FSM in IDLE after the fourth commit; the fifth press is ignored and note_count = 4.
REQ-040 stop issued during the second note of playback -> key_on = 0 the next cycle, playing = 0, and no play_done pulse.
REQ-041 rst asserted in REC_HOLD -> all outputs are 0 immediately; a subsequent play_start is ignored because note_count = 0.

Source files
------------

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared key width and recorder FSM state encoding
package piano_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REC_ARMED = 3'd1,
    REC_HOLD  = 3'd2,
    PLAY_NOTE = 3'd3,
    PLAY_GAP  = 3'd4
  } state_t;

endpackage

// File: rtl/song_recorder_if.sv
// rtl/song_recorder_if.sv - live keyboard, control pulses and playback outputs of the recorder
interface song_recorder_if
  import piano_pkg::*;
#(
  parameter int DEPTH = 32
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             key_on_in;
  logic [KEY_W-1:0] key_in;
  logic             rec_start;
  logic             play_start;
  logic             stop;
  logic             key_on;
  logic [KEY_W-1:0] key;
  logic             recording;
  logic             playing;
  logic             full;
  logic [CNT_W-1:0] note_count;
  logic             play_done;

  modport master (
    output key_on_in, key_in, rec_start, play_start, stop,
    input  key_on, key, recording, playing, full, note_count, play_done
  );

  modport slave (
    input  key_on_in, key_in, rec_start, play_start, stop,
    output key_on, key, recording, playing, full, note_count, play_done
  );

endinterface

// File: rtl/note_buffer.sv
// rtl/note_buffer.sv - note storage, one synchronous write port and one combinational read port
module note_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int WIDTH = 30
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  // contents are deliberately not reset; readers gate on note_count
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - records key presses with durations and replays them with a fixed gap
module song_recorder
  import piano_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DUR_W = 26,
  parameter int GAP   = 1
) (
  input  logic            clk,
  input  logic            rst,
  song_recorder_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int ENT_W = KEY_W + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [KEY_W-1:0] r_rec_key;
  logic [KEY_W-1:0] r_key_hold;
  logic [DUR_W-1:0] r_rec_dur;
  logic [DUR_W-1:0] r_play_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_play_done;

  logic             w_key_changed;
  logic             w_commit;
  logic             w_last_slot;
  logic             w_note_end;
  logic             w_gap_end;
  logic             w_last_note;
  logic [ENT_W-1:0] w_wr_data;
  logic [ENT_W-1:0] w_rd_data;
  logic [KEY_W-1:0] w_rd_key;
  logic [DUR_W-1:0] w_rd_dur;

  assign w_key_changed = bus.key_on_in && (bus.key_in != r_rec_key);
  assign w_commit      = (r_state == REC_HOLD) && (bus.stop || !bus.key_on_in || w_key_changed);
  assign w_last_slot   = (r_count == CNT_W'(DEPTH - 1));
  assign w_wr_data     = {r_rec_key, r_rec_dur};
  assign w_rd_key      = w_rd_data[ENT_W-1:DUR_W];
  assign w_rd_dur      = w_rd_data[DUR_W-1:0];
  assign w_note_end    = (r_play_cnt >= w_rd_dur);
  assign w_gap_end     = (r_gap_cnt >= GAP_W'(GAP));
  assign w_last_note   = (CNT_W'(r_rd_ptr) == (r_count - CNT_W'(1)));

  note_buffer #(
    .DEPTH (DEPTH),
    .AW    (PTR_W),
    .WIDTH (ENT_W)
  ) u_note_buffer (
    .i_clk     (clk),
    .i_wr_en   (w_commit),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.rec_start) begin
          w_state_next = REC_ARMED;
        end else if (bus.play_start && (r_count != '0)) begin
          w_state_next = PLAY_NOTE;
        end
      end
      REC_ARMED: begin
        if (bus.stop) begin
          w_state_next = IDLE;
        end else if (bus.key_on_in) begin
          w_state_next = REC_HOLD;
        end
      end
      REC_HOLD: begin
        // a key change commits and keeps holding, so only release leaves to REC_ARMED
        if (w_commit) begin
          if (w_last_slot || bus.stop) begin
            w_state_next = IDLE;
          end else if (!bus.key_on_in) begin
            w_state_next = REC_ARMED;
          end
        end
      end
      PLAY_NOTE: begin
        if (bus.stop) begin
          w_state_next = IDLE;
        end else if (w_note_end) begin
          w_state_next = PLAY_GAP;
        end
      end
      PLAY_GAP: begin
        if (bus.stop) begin
          w_state_next = IDLE;
        end else if (w_gap_end) begin
          w_state_next = w_last_note ? IDLE : PLAY_NOTE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rec_key   <= '0;
      r_key_hold  <= '0;
      r_rec_dur   <= '0;
      r_play_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_play_done <= 1'b0;
    end else begin
      r_play_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.rec_start) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
          end else if (bus.play_start && (r_count != '0)) begin
            r_rd_ptr   <= '0;
            r_play_cnt <= DUR_W'(1);
          end
        end
        REC_ARMED: begin
          if (!bus.stop && bus.key_on_in) begin
            r_rec_key <= bus.key_in;
            r_rec_dur <= DUR_W'(1);
          end
        end
        REC_HOLD: begin
          if (w_commit) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count  <= r_count + CNT_W'(1);
            if (w_key_changed && !bus.stop) begin
              r_rec_key <= bus.key_in;
              r_rec_dur <= DUR_W'(1);
            end
          end else if (r_rec_dur != DUR_MAX) begin
            r_rec_dur <= r_rec_dur + DUR_W'(1);
          end
        end
        PLAY_NOTE: begin
          r_key_hold <= w_rd_key;
          if (w_note_end) begin
            r_gap_cnt <= GAP_W'(1);
          end else begin
            r_play_cnt <= r_play_cnt + DUR_W'(1);
          end
        end
        PLAY_GAP: begin
          if (!bus.stop && w_gap_end) begin
            if (w_last_note) begin
              r_play_done <= 1'b1;
            end else begin
              r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
              r_play_cnt <= DUR_W'(1);
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // key reads the buffer only while a note sounds; otherwise the last played key is held
  always_comb begin
    bus.key_on     = (r_state == PLAY_NOTE);
    bus.key        = (r_state == PLAY_NOTE) ? w_rd_key : r_key_hold;
    bus.recording  = (r_state == REC_ARMED) || (r_state == REC_HOLD);
    bus.playing    = (r_state == PLAY_NOTE) || (r_state == PLAY_GAP);
    bus.full       = (r_count == CNT_W'(DEPTH));
    bus.note_count = r_count;
    bus.play_done  = r_play_done;
  end

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - directed bench with a note scoreboard checked against playback
module tb_song_recorder;
  import piano_pkg::*;

  localparam int DEPTH   = 4;
  localparam int DUR_W   = 8;
  localparam int GAP     = 1;
  localparam int DUR_SAT = (1 << DUR_W) - 1;

  typedef struct {
    logic [3:0] key;
    int         dur;
  } note_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  note_t exp_q[$];
  note_t mon_n;
  bit    mon_en = 1'b1;
  int    run_len = 0;
  logic [3:0] run_key = '0;

  song_recorder_if #(.DEPTH(DEPTH)) bus ();

  song_recorder #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W),
    .GAP   (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // each completed key_on run is one played note; compare it with the oldest recorded note
  always @(negedge clk) begin
    if (bus.key_on === 1'b1) begin
      if (run_len > 0) check("key_stable", 32'(bus.key), 32'(run_key));
      run_key = bus.key;
      run_len++;
    end else if (run_len > 0) begin
      if (mon_en) begin
        check("note_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_n = exp_q.pop_front();
          check("note_key", 32'(run_key), 32'(mon_n.key));
          check("note_dur", 32'(run_len), 32'(mon_n.dur));
        end
      end
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rec_start();
    bus.rec_start = 1'b1;
    tick();
    bus.rec_start = 1'b0;
  endtask

  task automatic do_play();
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic press(input logic [3:0] k, input int n, input bit push);
    note_t e;
    bus.key_on_in = 1'b1;
    bus.key_in    = k;
    repeat (n) tick();
    if (push) begin
      e.key = k;
      e.dur = (n > DUR_SAT) ? DUR_SAT : n;
      exp_q.push_back(e);
    end
  endtask

  task automatic release_key();
    bus.key_on_in = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.play_done === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_on"},     32'(bus.key_on),     32'(0));
    check({tag, "_key"},        32'(bus.key),        32'(0));
    check({tag, "_recording"},  32'(bus.recording),  32'(0));
    check({tag, "_playing"},    32'(bus.playing),    32'(0));
    check({tag, "_full"},       32'(bus.full),       32'(0));
    check({tag, "_note_count"}, 32'(bus.note_count), 32'(0));
    check({tag, "_play_done"},  32'(bus.play_done),  32'(0));
  endtask

  initial begin
    bus.key_on_in  = 1'b0;
    bus.key_in     = '0;
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.stop       = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // single note of 5 cycles, gap of 1, then play_done
    do_rec_start();
    check("armed_recording", 32'(bus.recording), 32'(1));
    press(4'd2, 5, 1'b1);
    release_key();
    do_stop();
    check("rec_stopped", 32'(bus.recording), 32'(0));
    check("one_note_count", 32'(bus.note_count), 32'(1));
    do_play();
    for (int i = 0; i < 5; i++) begin
      check("n1_key_on", 32'(bus.key_on), 32'(1));
      check("n1_key", 32'(bus.key), 32'(2));
      tick();
    end
    check("n1_gap_key_on", 32'(bus.key_on), 32'(0));
    check("n1_gap_playing", 32'(bus.playing), 32'(1));
    check("n1_done_early", 32'(bus.play_done), 32'(0));
    tick();
    check("n1_play_done", 32'(bus.play_done), 32'(1));
    check("n1_idle", 32'(bus.playing), 32'(0));
    check("n1_key_hold", 32'(bus.key), 32'(2));
    tick();
    check("n1_done_pulse", 32'(bus.play_done), 32'(0));

    // duration saturates at 255
    do_rec_start();
    press(4'd3, 300, 1'b1);
    release_key();
    do_stop();
    check("sat_count", 32'(bus.note_count), 32'(1));
    do_play();
    wait_done(400, "sat_done");

    // key change without release splits into two notes
    do_rec_start();
    check("clear_count", 32'(bus.note_count), 32'(0));
    press(4'd1, 4, 1'b1);
    press(4'd4, 6, 1'b1);
    release_key();
    do_stop();
    check("split_count", 32'(bus.note_count), 32'(2));
    do_play();
    wait_done(100, "split_done");

    // fill the buffer, fifth press ignored
    do_rec_start();
    press(4'd5, 3, 1'b1);
    release_key();
    press(4'd6, 4, 1'b1);
    release_key();
    press(4'd7, 2, 1'b1);
    release_key();
    check("three_count", 32'(bus.note_count), 32'(3));
    check("three_not_full", 32'(bus.full), 32'(0));
    press(4'd8, 5, 1'b1);
    release_key();
    check("full_flag", 32'(bus.full), 32'(1));
    check("full_idle", 32'(bus.recording), 32'(0));
    check("full_count", 32'(bus.note_count), 32'(4));
    press(4'd9, 3, 1'b0);
    release_key();
    check("fifth_ignored", 32'(bus.note_count), 32'(4));
    check("fifth_idle", 32'(bus.recording), 32'(0));
    do_play();
    wait_done(100, "full_done");
    check("full_queue_empty", 32'(exp_q.size()), 32'(0));

    // stop during the second note of playback
    mon_n.key = 4'd5;
    mon_n.dur = 3;
    exp_q.push_back(mon_n);
    do_play();
    repeat (3) tick();
    tick();
    check("n2_key_on", 32'(bus.key_on), 32'(1));
    check("n2_key", 32'(bus.key), 32'(6));
    mon_en = 1'b0;
    do_stop();
    check("abort_key_on", 32'(bus.key_on), 32'(0));
    check("abort_playing", 32'(bus.playing), 32'(0));
    check("abort_key_hold", 32'(bus.key), 32'(6));
    for (int i = 0; i < 5; i++) begin
      check("abort_no_done", 32'(bus.play_done), 32'(0));
      tick();
    end
    check("abort_queue_empty", 32'(exp_q.size()), 32'(0));
    mon_en = 1'b1;

    // asynchronous reset in the middle of a held note
    do_rec_start();
    bus.key_on_in = 1'b1;
    bus.key_in    = 4'd7;
    repeat (3) tick();
    check("hold_recording", 32'(bus.recording), 32'(1));
    rst = 1'b1;
    #1;
    check_all_zero("midrec_rst");
    bus.key_on_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_play();
    check("post_rst_playing", 32'(bus.playing), 32'(0));
    check("post_rst_key_on", 32'(bus.key_on), 32'(0));
    check("post_rst_count", 32'(bus.note_count), 32'(0));
    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
